// File: rtl/as_imem_arb.sv
// I-Mem access arbiter and JTAG load sequencer.
// Shares the single I-Mem port between the core fetch path and the scan
// loader. The loader side has a small write FIFO, a bulk-erase sequencer and
// a readback path. The core is held while loader traffic is pending.
module as_imem_arb #(
  parameter int imem_addr_width = 10,
  parameter int instr_width     = 32,
  parameter int fifo_depth      = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  // scan loader side
  input  logic                       scan_valid_i,
  input  logic [imem_addr_width-1:0] scan_addr_i,
  input  logic [instr_width-1:0]     scan_data_i,
  input  logic                       scan_we_i,
  output logic                       scan_ready_o,
  output logic [instr_width-1:0]     scan_rdata_o,
  output logic                       scan_rvalid_o,
  // bulk erase
  input  logic                       erase_req_i,
  input  logic [imem_addr_width-2:0] erase_words_i,
  // core fetch side
  input  logic                       fetch_req_i,
  input  logic [imem_addr_width-1:0] fetch_addr_i,
  output logic                       fetch_gnt_o,
  output logic [instr_width-1:0]     fetch_rdata_o,
  output logic                       fetch_valid_o,
  // I-Mem port
  output logic [imem_addr_width-1:0] mem_addr_o,
  output logic [instr_width-1:0]     mem_wdata_o,
  output logic                       mem_we_o,
  output logic                       mem_re_o,
  input  logic [instr_width-1:0]     mem_rdata_i,
  // status
  output logic                       core_hold_o,
  output logic                       busy_o,
  output logic                       err_o
);

  localparam int ptr_w = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam int cnt_w = imem_addr_width - 1;
  localparam logic [ptr_w:0] full_cnt = (ptr_w + 1)'(fifo_depth);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ERASE,
    ST_WRITE,
    ST_READ
  } state_e;

  typedef struct packed {
    logic [imem_addr_width-1:0] addr;
    logic [instr_width-1:0]     data;
    logic                       we;
  } scan_entry_t;

  state_e                 state_q, state_d;
  scan_entry_t            fifo_mem_q [fifo_depth];
  logic [ptr_w-1:0]       wr_ptr_q, wr_ptr_d;
  logic [ptr_w-1:0]       rd_ptr_q, rd_ptr_d;
  logic [ptr_w:0]         count_q, count_d;
  scan_entry_t            op_q, op_d;
  logic [cnt_w-1:0]       cnt_q, cnt_d;
  logic [cnt_w-1:0]       erase_last_q, erase_last_d;
  logic [instr_width-1:0] rdata_q, rdata_d;
  logic                   rd_pend_q, rd_pend_d;
  logic                   fetch_valid_q, fetch_valid_d;
  logic                   err_q, err_d;
  logic                   scan_ready_q, scan_ready_d;
  logic                   core_hold_q, core_hold_d;

  logic        fifo_empty, fifo_full, is_idle;
  logic        misaligned, push, drop, pop;
  logic        erase_acc, erase_bad, fetch_gnt, busy;
  scan_entry_t push_entry;

  // Arbitration terms: loader work always wins over a core fetch.
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == full_cnt);
  assign is_idle    = (state_q == ST_IDLE);
  assign misaligned = |scan_addr_i[1:0];
  assign push       = scan_valid_i & ~fifo_full & ~misaligned;
  assign drop       = scan_valid_i & (fifo_full | misaligned);
  assign erase_acc  = erase_req_i & is_idle & fifo_empty;
  assign erase_bad  = erase_req_i & ~erase_acc;
  assign pop        = is_idle & ~fifo_empty;
  assign fetch_gnt  = fetch_req_i & is_idle & fifo_empty & ~erase_acc;
  assign busy       = ~fifo_empty | ~is_idle | erase_acc;
  assign push_entry = '{addr: scan_addr_i, data: scan_data_i, we: scan_we_i};

  // State register; reset aborts any loader operation immediately.
  // NOTE: sequential blocks use non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours; blocking here would create order races.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: erase first, then queued scan work, otherwise stay idle.
  always_comb begin
    // NOTE: defaulting every comb output at the top guarantees no path leaves
    // it unassigned, so no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (erase_acc) begin
          if (erase_words_i != '0) state_d = ST_ERASE;
        end else if (pop) begin
          state_d = fifo_mem_q[rd_ptr_q].we ? ST_WRITE : ST_READ;
        end
      end
      ST_ERASE: if (cnt_q == erase_last_q) state_d = ST_IDLE;
      ST_WRITE: state_d = ST_IDLE;
      ST_READ:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Memory-port and grant outputs decoded from the current state.
  always_comb begin
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_we_o    = 1'b0;
    mem_re_o    = 1'b0;
    fetch_gnt_o = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (fetch_gnt) begin
          fetch_gnt_o = 1'b1;
          mem_re_o    = 1'b1;
          mem_addr_o  = fetch_addr_i;
        end
      end
      ST_ERASE: begin
        mem_we_o   = 1'b1;
        mem_addr_o = {cnt_q[imem_addr_width-3:0], 2'b00};
      end
      ST_WRITE: begin
        mem_we_o    = 1'b1;
        mem_addr_o  = op_q.addr;
        mem_wdata_o = op_q.data;
      end
      ST_READ: begin
        mem_re_o   = 1'b1;
        mem_addr_o = op_q.addr;
      end
      default: ;
    endcase
  end

  // Datapath next values: FIFO pointers, erase counter, readback and status.
  always_comb begin
    wr_ptr_d      = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d      = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d       = count_q + {{ptr_w{1'b0}}, push} - {{ptr_w{1'b0}}, pop};
    scan_ready_d  = (count_d != full_cnt);
    op_d          = pop ? fifo_mem_q[rd_ptr_q] : op_q;
    erase_last_d  = erase_acc ? erase_words_i - cnt_w'(1) : erase_last_q;
    cnt_d         = cnt_q;
    if (state_q == ST_ERASE) cnt_d = (cnt_q == erase_last_q) ? '0 : cnt_q + 1'b1;
    rd_pend_d     = (state_q == ST_READ);
    rdata_d       = rd_pend_q ? mem_rdata_i : rdata_q;
    fetch_valid_d = fetch_gnt;
    err_d         = err_q | drop | erase_bad;
    core_hold_d   = busy;
  end

  // Control and status flops.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      scan_ready_q  <= 1'b1;
      op_q          <= '0;
      erase_last_q  <= '0;
      cnt_q         <= '0;
      rd_pend_q     <= 1'b0;
      rdata_q       <= '0;
      fetch_valid_q <= 1'b0;
      err_q         <= 1'b0;
      core_hold_q   <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      scan_ready_q  <= scan_ready_d;
      op_q          <= op_d;
      erase_last_q  <= erase_last_d;
      cnt_q         <= cnt_d;
      rd_pend_q     <= rd_pend_d;
      rdata_q       <= rdata_d;
      fetch_valid_q <= fetch_valid_d;
      err_q         <= err_d;
      core_hold_q   <= core_hold_d;
    end
  end

  // FIFO storage; occupancy is tracked by the pointers and count alone.
  // NOTE: the storage array has no reset: stale entries are never read
  // because count_q gates every pop, and skipping reset keeps it RAM-friendly.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem_q[wr_ptr_q] <= push_entry;
  end

  // Readback and fetch data pass through the cycle after the memory read.
  assign scan_rvalid_o = rd_pend_q;
  assign scan_rdata_o  = rd_pend_q ? mem_rdata_i : rdata_q;
  assign fetch_valid_o = fetch_valid_q;
  assign fetch_rdata_o = fetch_valid_q ? mem_rdata_i : '0;
  assign scan_ready_o  = scan_ready_q;
  assign busy_o        = busy;
  assign core_hold_o   = core_hold_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_as_imem_arb.sv
// Self-checking bench for as_imem_arb: a transaction-level model (FIFO queue
// plus a schedule of future memory operations) is stepped every cycle and
// compared with the DUT, alongside directed scenarios with literal checks.
module tb_as_imem_arb;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          scan_valid_i = 1'b0;
  logic [AW-1:0] scan_addr_i = '0;
  logic [DW-1:0] scan_data_i = '0;
  logic          scan_we_i = 1'b0;
  logic          scan_ready_o;
  logic [DW-1:0] scan_rdata_o;
  logic          scan_rvalid_o;
  logic          erase_req_i = 1'b0;
  logic [AW-2:0] erase_words_i = '0;
  logic          fetch_req_i = 1'b0;
  logic [AW-1:0] fetch_addr_i = '0;
  logic          fetch_gnt_o;
  logic [DW-1:0] fetch_rdata_o;
  logic          fetch_valid_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_we_o;
  logic          mem_re_o;
  logic [DW-1:0] mem_rdata_i = '0;
  logic          core_hold_o;
  logic          busy_o;
  logic          err_o;

  as_imem_arb #(.imem_addr_width(AW), .instr_width(DW), .fifo_depth(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .scan_valid_i(scan_valid_i), .scan_addr_i(scan_addr_i), .scan_data_i(scan_data_i),
    .scan_we_i(scan_we_i), .scan_ready_o(scan_ready_o), .scan_rdata_o(scan_rdata_o),
    .scan_rvalid_o(scan_rvalid_o), .erase_req_i(erase_req_i), .erase_words_i(erase_words_i),
    .fetch_req_i(fetch_req_i), .fetch_addr_i(fetch_addr_i), .fetch_gnt_o(fetch_gnt_o),
    .fetch_rdata_o(fetch_rdata_o), .fetch_valid_o(fetch_valid_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_we_o(mem_we_o),
    .mem_re_o(mem_re_o), .mem_rdata_i(mem_rdata_i),
    .core_hold_o(core_hold_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // I-Mem macro stand-in: synchronous write, one-cycle read latency.
  logic [DW-1:0] imem [256];
  always @(posedge clk_i) begin
    if (mem_we_o) imem[mem_addr_o[9:2]] <= mem_wdata_o;
    if (mem_re_o) mem_rdata_i <= imem[mem_addr_o[9:2]];
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {bit we; bit [9:0] addr; bit [31:0] data;} entry_t;
  typedef struct {bit we; bit re; bit [9:0] addr; bit [31:0] data;} op_t;
  typedef struct {bit [9:0] a; bit [31:0] d;} wr_t;

  entry_t    q[$];        // scan words waiting in the loader FIFO
  op_t       sched[$];    // loader memory operations owed in coming cycles
  wr_t       wlog[$];     // observed DUT writes, for directed checks
  bit [31:0] ref_mem [256];
  bit        m_err, m_hold, m_fv, m_rv;
  bit [31:0] m_fdata, m_rdata;

  task automatic model_reset();
    q.delete();
    sched.delete();
    m_err = 0; m_hold = 0; m_fv = 0; m_rv = 0; m_rdata = '0; m_fdata = '0;
  endtask

  task automatic model_step();
    op_t    op;
    entry_t e;
    bit     idle, e_acc, e_gnt, e_re, e_busy;
    bit [9:0] e_addr;
    int     n0;
    op = '{default: 0};
    idle = (sched.size() == 0);
    if (!idle) op = sched.pop_front();
    n0     = q.size();
    e_acc  = idle && n0 == 0 && erase_req_i;
    e_gnt  = idle && n0 == 0 && !e_acc && fetch_req_i;
    e_re   = op.re || e_gnt;
    e_addr = e_gnt ? fetch_addr_i : op.addr;
    e_busy = (n0 != 0) || !idle || e_acc;
    if (mem_we_o) wlog.push_back('{a: mem_addr_o, d: mem_wdata_o});

    check("fetch_gnt", fetch_gnt_o, e_gnt);
    check("mem_we", mem_we_o, op.we);
    check("mem_re", mem_re_o, e_re);
    if (op.we || e_re) check("mem_addr", mem_addr_o, e_addr);
    if (op.we) check("mem_wdata", mem_wdata_o, op.data);
    check("busy", busy_o, e_busy);
    check("core_hold", core_hold_o, m_hold);
    check("scan_ready", scan_ready_o, n0 < 2);
    check("err", err_o, m_err);
    check("fetch_valid", fetch_valid_o, m_fv);
    if (m_fv) check("fetch_rdata", fetch_rdata_o, m_fdata);
    check("scan_rvalid", scan_rvalid_o, m_rv);
    check("scan_rdata", scan_rdata_o, m_rdata);

    // advance to the next cycle
    m_rv = op.re;
    if (op.re) m_rdata = ref_mem[op.addr[9:2]];
    if (op.we) ref_mem[op.addr[9:2]] = op.data;
    m_fv = e_gnt;
    if (e_gnt) m_fdata = ref_mem[fetch_addr_i[9:2]];
    if (idle && n0 != 0) begin
      e = q.pop_front();
      sched.push_back('{we: e.we, re: !e.we, addr: e.addr, data: e.data});
    end
    if (erase_req_i && !e_acc) m_err = 1;
    if (e_acc)
      for (int i = 0; i < int'(erase_words_i); i++)
        sched.push_back('{we: 1, re: 0, addr: 10'(i * 4), data: '0});
    if (scan_valid_i) begin
      if (scan_addr_i[1:0] != 2'b00 || n0 >= 2) m_err = 1;
      else q.push_back('{we: scan_we_i, addr: scan_addr_i, data: scan_data_i});
    end
    m_hold = e_busy;
  endtask

  initial begin
    forever begin
      @(negedge clk_i);
      if (!rst_i) model_reset();
      else        model_step();
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [31:0] iram [5] = '{32'h00500093, 32'h00a00113, 32'h002081b3,
                            32'h00302023, 32'h0000006f};

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    scan_valid_i = 0; scan_we_i = 0; erase_req_i = 0; fetch_req_i = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_scan_ready"}, scan_ready_o, 1);
    check({tag, "_scan_rdata"}, scan_rdata_o, 0);
    check({tag, "_scan_rvalid"}, scan_rvalid_o, 0);
    check({tag, "_fetch_gnt"}, fetch_gnt_o, 0);
    check({tag, "_fetch_rdata"}, fetch_rdata_o, 0);
    check({tag, "_fetch_valid"}, fetch_valid_o, 0);
    check({tag, "_mem_addr"}, mem_addr_o, 0);
    check({tag, "_mem_wdata"}, mem_wdata_o, 0);
    check({tag, "_mem_we"}, mem_we_o, 0);
    check({tag, "_mem_re"}, mem_re_o, 0);
    check({tag, "_core_hold"}, core_hold_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_err"}, err_o, 0);
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_i = 0;
    tick();
    tick();
    rst_i = 1;
    tick();
  endtask

  task automatic scan(input logic [9:0] a, input logic [31:0] d, input logic we);
    scan_valid_i = 1; scan_addr_i = a; scan_data_i = d; scan_we_i = we;
    tick();
    scan_valid_i = 0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!scan_ready_o && n < 100) begin tick(); n++; end
    check("ready_timeout", scan_ready_o, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy_o || core_hold_o || scan_rvalid_o) && n < 300) begin tick(); n++; end
    check("idle_timeout", busy_o | core_hold_o, 0);
  endtask

  task automatic fetch(input logic [9:0] a, input logic [31:0] exp, input string name);
    int n = 0;
    fetch_req_i = 1; fetch_addr_i = a;
    #1;
    while (!fetch_gnt_o && n < 100) begin tick(); n++; end
    check({name, "_gnt"}, fetch_gnt_o, 1);
    tick();
    fetch_req_i = 0;
    check({name, "_valid"}, fetch_valid_o, 1);
    check({name, "_rdata"}, fetch_rdata_o, exp);
  endtask

  task automatic check_log_erase_then(input int n_erase, input int n_data);
    check("log_size", wlog.size(), n_erase + n_data);
    if (wlog.size() == n_erase + n_data)
      for (int i = 0; i < n_erase; i++) begin
        check("log_erase_addr", wlog[i].a, 10'(i * 4));
        check("log_erase_data", wlog[i].d, 0);
      end
  endtask

  // ---------------- directed and random sequences ----------------
  initial begin
    logic [5:0] g;
    int k, n;
    for (int i = 0; i < 256; i++) begin
      imem[i] = $urandom;
      ref_mem[i] = imem[i];
    end
    repeat (2) @(posedge clk_i);
    #1;
    check_reset_outputs("rst0");
    rst_i = 1;
    tick();

    // Erase five words, then load five words at 0x000..0x010.
    wlog.delete();
    erase_req_i = 1; erase_words_i = 5;
    tick();
    erase_req_i = 0;
    for (int i = 0; i < 5; i++) begin
      wait_ready();
      scan(10'(i * 4), iram[i], 1'b1);
    end
    wait_idle();
    check("t1_core_hold", core_hold_o, 0);
    check_log_erase_then(5, 5);
    if (wlog.size() == 10)
      for (int i = 0; i < 5; i++) begin
        check("t1_load_addr", wlog[5 + i].a, 10'(i * 4));
        check("t1_load_data", wlog[5 + i].d, iram[i]);
      end
    do_reset();
    fetch(10'h000, iram[0], "t1_fetch0");

    // Reset in erase cycle 3 of N=5: earlier words stay written.
    wait_idle();
    wlog.delete();
    erase_req_i = 1; erase_words_i = 5;
    tick();
    erase_req_i = 0;
    tick();
    tick();
    check("t2_we_before_rst", mem_we_o, 1);
    check("t2_addr_before_rst", mem_addr_o, 10'h008);
    rst_i = 0;
    #1;
    check_reset_outputs("t2_rst");
    tick();
    tick();
    rst_i = 1;
    tick();
    check("t2_log_size", wlog.size(), 2);
    fetch(10'h010, iram[4], "t2_fetch10");

    // Fetch contention with two back-to-back scan writes.
    wait_idle();
    fetch_req_i = 1; fetch_addr_i = 10'h020;
    scan_valid_i = 1; scan_addr_i = 10'h080; scan_data_i = 32'h11112222; scan_we_i = 1;
    #1; g[0] = fetch_gnt_o;
    tick();
    scan_addr_i = 10'h084; scan_data_i = 32'h33334444;
    #1; g[1] = fetch_gnt_o;
    tick();
    scan_valid_i = 0;
    for (int i = 2; i < 6; i++) begin
      #1; g[i] = fetch_gnt_o;
      if (i < 5) tick();
    end
    check("t3_gnt_pattern", g, 6'b100001);
    tick();
    fetch_req_i = 0;
    check("t3_fetch_valid", fetch_valid_o, 1);

    // Overflow while the FIFO waits behind an 8-word erase.
    do_reset();
    wlog.delete();
    erase_req_i = 1; erase_words_i = 8;
    tick();
    erase_req_i = 0;
    scan(10'h200, 32'hA0A0A0A0, 1'b1);
    scan(10'h204, 32'hB0B0B0B0, 1'b1);
    scan(10'h208, 32'hC0C0C0C0, 1'b1);
    wait_idle();
    check("t4_err", err_o, 1);
    check_log_erase_then(8, 2);
    if (wlog.size() == 10) begin
      check("t4_w0_addr", wlog[8].a, 10'h200);
      check("t4_w0_data", wlog[8].d, 32'hA0A0A0A0);
      check("t4_w1_addr", wlog[9].a, 10'h204);
      check("t4_w1_data", wlog[9].d, 32'hB0B0B0B0);
    end

    // Misaligned scan write is dropped.
    do_reset();
    wlog.delete();
    scan(10'h006, 32'h12345678, 1'b1);
    wait_idle();
    check("t5_misalign_err", err_o, 1);
    check("t5_misalign_log", wlog.size(), 0);

    // Erase while the FIFO holds a word is ignored.
    do_reset();
    wlog.delete();
    scan(10'h040, 32'h55AA55AA, 1'b1);
    erase_req_i = 1; erase_words_i = 4;
    tick();
    erase_req_i = 0;
    wait_idle();
    check("t5_bad_erase_err", err_o, 1);
    check("t5_bad_erase_log", wlog.size(), 1);
    if (wlog.size() == 1) check("t5_bad_erase_addr", wlog[0].a, 10'h040);

    // Readback of a freshly written word, three cycles after the push.
    do_reset();
    scan(10'h100, 32'hDEADBEEF, 1'b1);
    wait_idle();
    k = cyc;
    scan(10'h100, 32'h0, 1'b0);
    n = 0;
    while (!scan_rvalid_o && n < 10) begin tick(); n++; end
    check("t6_rvalid", scan_rvalid_o, 1);
    check("t6_latency", cyc - k, 3);
    check("t6_rdata", scan_rdata_o, 32'hDEADBEEF);
    tick();
    check("t6_rdata_held", scan_rdata_o, 32'hDEADBEEF);

    // Randomized traffic with occasional asynchronous resets.
    for (int c = 0; c < 2500; c++) begin
      if (c % 500 == 250) do_reset();
      scan_valid_i  = ($urandom % 4) == 0;
      scan_addr_i   = {8'($urandom), 2'b00};
      if (($urandom % 8) == 0) scan_addr_i[1:0] = 2'($urandom_range(1, 3));
      scan_data_i   = $urandom;
      scan_we_i     = ($urandom % 3) != 0;
      erase_req_i   = ($urandom % 40) == 0;
      erase_words_i = 9'($urandom_range(0, 6));
      fetch_req_i   = $urandom % 2;
      fetch_addr_i  = {8'($urandom), 2'b00};
      tick();
    end
    clear_inputs();
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

endmodule
